// File: rtl/mem_stage_access_unit.sv
// ---------------------------------------------------------------------------
// mem_stage_access_unit
//
// Memory-stage access sequencer. Takes one scalar or 128-bit vector
// load/store from the Execute->Memory register and turns it into 32-bit
// data-memory beats on a valid/ready handshake. The unit stalls the pipeline
// until the access has finished and returns the formatted load result.
//
// Ports
//   clock                 rising-edge clock
//   async_reset           asynchronous, active-low reset
//   sync_reset            synchronous, active-low abort/clear
//   memory_transaction_M  current instruction accesses memory
//   mem_write_M           1 = store, 0 = load
//   width_type_M          000 B, 001 H, 010 W, 100 BU, 101 HU, 011 vector
//   ALU_result_bus_M      effective address in [31:0]
//   write_data_bus_M      store data (scalar in [31:0])
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be  beat request to data memory
//   mem_ready/mem_rdata   beat accept and read data (valid same cycle)
//   read_data_M           load result
//   stall_M               combinational hold for upstream stages
//   misaligned_M          one-cycle pulse in DONE for a misaligned access
// ---------------------------------------------------------------------------
module mem_stage_access_unit #(
  parameter int VECTOR_BEATS = 4,
  parameter int BEAT_STRIDE  = 4
) (
  input  logic         clock,
  input  logic         async_reset,
  input  logic         sync_reset,
  input  logic         memory_transaction_M,
  input  logic         mem_write_M,
  input  logic [2:0]   width_type_M,
  input  logic [127:0] ALU_result_bus_M,
  input  logic [127:0] write_data_bus_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [31:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  output logic [3:0]   mem_be,
  input  logic         mem_ready,
  input  logic [31:0]  mem_rdata,
  output logic [127:0] read_data_M,
  output logic         stall_M,
  output logic         misaligned_M
);

  localparam int CNT_W = (VECTOR_BEATS > 1) ? $clog2(VECTOR_BEATS) : 1;

  localparam logic [2:0] W_B   = 3'b000;
  localparam logic [2:0] W_H   = 3'b001;
  localparam logic [2:0] W_W   = 3'b010;
  localparam logic [2:0] W_VEC = 3'b011;
  localparam logic [2:0] W_BU  = 3'b100;
  localparam logic [2:0] W_HU  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_width;
  logic [1:0]         r_addr_lo;
  logic [95:0]        r_wdata_rest;
  logic               r_mem_req;
  logic               r_mem_we;
  logic [31:0]        r_mem_addr;
  logic [31:0]        r_mem_wdata;
  logic [3:0]         r_mem_be;
  logic [127:0]       r_rd;
  logic               r_mis;

  logic [31:0]        w_addr;
  logic               w_misaligned;
  logic               w_beat_done;
  logic               w_vec;
  logic               w_last;
  logic [6:0]         w_rd_lsb;
  logic               w_unused_addr_hi;

  // Halfwords need an even address; words and vectors need word alignment.
  function automatic logic is_misaligned(input logic [2:0] w, input logic [1:0] lo);
    case (w)
      W_H, W_HU:  return lo[0];
      W_W, W_VEC: return |lo;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] fmt_be(input logic we, input logic [2:0] w, input logic [1:0] lo);
    if (!we)            return 4'b1111;
    else if (w == W_B)  return 4'b0001 << lo;
    else if (w == W_H)  return 4'b0011 << lo;
    else                return 4'b1111;
  endfunction

  // Sub-word stores replicate the datum across the word so the byte enables
  // alone select the destination lane.
  function automatic logic [31:0] fmt_wdata(input logic [2:0] w, input logic [31:0] d);
    case (w)
      W_B:     return {4{d[7:0]}};
      W_H:     return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] fmt_load(input logic [2:0] w, input logic [1:0] lo,
                                           input logic [31:0] d);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = 8'(d >> {lo, 3'b000});
    h = lo[1] ? d[31:16] : d[15:0];
    case (w)
      W_B:     return {{24{b[7]}}, b};
      W_BU:    return {24'b0, b};
      W_H:     return {{16{h[15]}}, h};
      W_HU:    return {16'b0, h};
      default: return d;
    endcase
  endfunction

  assign w_addr           = ALU_result_bus_M[31:0];
  assign w_unused_addr_hi = |ALU_result_bus_M[127:32];
  assign w_misaligned     = is_misaligned(width_type_M, w_addr[1:0]);
  assign w_beat_done      = (r_state == S_ACCESS) && r_mem_req && mem_ready;
  assign w_vec            = (r_width == W_VEC);
  assign w_last           = !w_vec || (r_cnt == CNT_W'(VECTOR_BEATS - 1));
  assign w_rd_lsb         = 7'(r_cnt) << 5;

  // ---- FSM state register ----
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset)     r_state <= S_IDLE;
    else if (!sync_reset) r_state <= S_IDLE;
    else                  r_state <= w_next_state;
  end

  // ---- FSM next-state ----
  // ACCESS ignores memory_transaction_M so a flushed access still finishes.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (memory_transaction_M) w_next_state = w_misaligned ? S_DONE : S_ACCESS;
      S_ACCESS: if (w_beat_done && w_last) w_next_state = S_DONE;
      S_DONE:   w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // ---- FSM outputs ----
  // The pipeline advances only in DONE, so the access is never reissued.
  always_comb begin
    stall_M = memory_transaction_M && (r_state != S_DONE);
  end

  // ---- beat request / load result registers ----
  always_ff @(posedge clock or negedge async_reset) begin
    if (!async_reset || !sync_reset) begin
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_rd        <= '0;
      r_mis       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (memory_transaction_M) begin
          r_cnt <= '0;
          if (w_misaligned) begin
            r_mis <= 1'b1;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= mem_write_M;
            r_mem_addr  <= {w_addr[31:2], 2'b00};
            r_mem_be    <= fmt_be(mem_write_M, width_type_M, w_addr[1:0]);
            r_mem_wdata <= fmt_wdata(width_type_M, write_data_bus_M[31:0]);
          end
        end
        S_ACCESS: if (w_beat_done) begin
          if (!r_mem_we) begin
            if (w_vec) r_rd[w_rd_lsb +: 32] <= mem_rdata;
            else       r_rd <= {96'b0, fmt_load(r_width, r_addr_lo, mem_rdata)};
          end
          if (w_last) begin
            r_mem_req <= 1'b0;
          end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
            r_mem_addr  <= r_mem_addr + 32'(BEAT_STRIDE);
            r_mem_wdata <= r_wdata_rest[31:0];
          end
        end
        S_DONE: r_mis <= 1'b0;
        default: ;
      endcase
    end
  end

  // ---- latched access attributes (data only, no reset) ----
  // Remaining vector store words shift down one slot per completed beat.
  always_ff @(posedge clock) begin
    if (r_state == S_IDLE && memory_transaction_M) begin
      r_width      <= width_type_M;
      r_addr_lo    <= w_addr[1:0];
      r_wdata_rest <= write_data_bus_M[127:32];
    end else if (w_beat_done) begin
      r_wdata_rest <= r_wdata_rest >> 32;
    end
  end

  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign mem_be       = r_mem_be;
  assign read_data_M  = r_rd;
  assign misaligned_M = r_mis;

endmodule
